// File: rtl/milano_pkg.sv
// Shared types for the milano core.
package milano_pkg;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_opt_e;

endpackage

// File: rtl/md_unit_if.sv
// ID-EX to md_unit request/result bundle; signal names follow the unit's own port view.
interface md_unit_if;

  logic                  md_sel_i;
  logic [31:0]           md_operand_a_i;
  logic [31:0]           md_operand_b_i;
  milano_pkg::md_opt_e   md_operate_i;
  logic [4:0]            rd_addr_i;
  logic                  stall_req_o;
  logic                  result_valid_o;
  logic [31:0]           result_o;
  logic [4:0]            rd_addr_o;
  logic                  rd_wr_en_o;

  modport master (
    output md_sel_i, md_operand_a_i, md_operand_b_i, md_operate_i, rd_addr_i,
    input  stall_req_o, result_valid_o, result_o, rd_addr_o, rd_wr_en_o
  );

  modport slave (
    input  md_sel_i, md_operand_a_i, md_operand_b_i, md_operate_i, rd_addr_i,
    output stall_req_o, result_valid_o, result_o, rd_addr_o, rd_wr_en_o
  );

endinterface

// File: rtl/md_unit.sv
// RV32M multiply/divide unit: single-cycle registered multiply, 32-step restoring divide.
module md_unit (
  input  logic       clk_i,
  input  logic       rst_ni,
  md_unit_if.slave   md_if
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e              state_q, state_d;
  milano_pkg::md_opt_e op_q, op_d;
  logic [31:0]         a_q, a_d, b_q, b_d, rem_q, rem_d, res_q, res_d;
  logic [4:0]          rd_q, rd_d, rd_out_q, rd_out_d, cnt_q, cnt_d;
  logic                negq_q, negq_d, negr_q, negr_d;
  logic                stall, valid;

  // Request decode, only meaningful in IDLE
  milano_pkg::md_opt_e in_op;
  logic [31:0]         in_a, in_b, a_mag, b_mag, special_res;
  logic                in_is_mul, in_signed, in_is_rem, div_by_zero, div_ovf;

  assign in_op       = md_if.md_operate_i;
  assign in_a        = md_if.md_operand_a_i;
  assign in_b        = md_if.md_operand_b_i;
  assign in_is_mul   = (in_op == milano_pkg::MD_MUL)    || (in_op == milano_pkg::MD_MULH) ||
                       (in_op == milano_pkg::MD_MULHSU) || (in_op == milano_pkg::MD_MULHU);
  assign in_signed   = (in_op == milano_pkg::MD_DIV) || (in_op == milano_pkg::MD_REM);
  assign in_is_rem   = (in_op == milano_pkg::MD_REM) || (in_op == milano_pkg::MD_REMU);
  assign a_mag       = (in_signed && in_a[31]) ? (~in_a + 32'd1) : in_a;
  assign b_mag       = (in_signed && in_b[31]) ? (~in_b + 32'd1) : in_b;
  assign div_by_zero = (in_b == '0);
  assign div_ovf     = in_signed && (in_a == 32'h8000_0000) && (in_b == '1);
  assign special_res = div_by_zero ? (in_is_rem ? in_a : '1)
                                   : (in_is_rem ? '0 : 32'h8000_0000);

  // Multiply: sign-extend to 64 bits so the low 64 bits of an unsigned product are exact
  logic        mul_sa, mul_sb;
  logic [63:0] ext_a, ext_b, prod;

  assign mul_sa = (op_q != milano_pkg::MD_MULHU);
  assign mul_sb = (op_q == milano_pkg::MD_MUL) || (op_q == milano_pkg::MD_MULH);
  assign ext_a  = {{32{mul_sa & a_q[31]}}, a_q};
  assign ext_b  = {{32{mul_sb & b_q[31]}}, b_q};
  assign prod   = ext_a * ext_b;

  // Divide step: a_q shifts the dividend out MSB-first and the quotient in LSB-first
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff, rem_next, q_next, q_final, r_final;
  logic        op_is_rem;

  assign shifted   = {rem_q, a_q[31]};
  assign ge        = (shifted >= {1'b0, b_q});
  assign diff      = shifted[31:0] - b_q;
  assign rem_next  = ge ? diff : shifted[31:0];
  assign q_next    = {a_q[30:0], ge};
  assign q_final   = negq_q ? (~q_next + 32'd1) : q_next;
  assign r_final   = negr_q ? (~rem_next + 32'd1) : rem_next;
  assign op_is_rem = (op_q == milano_pkg::MD_REM) || (op_q == milano_pkg::MD_REMU);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    res_d    = res_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    stall    = 1'b0;
    valid    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (md_if.md_sel_i) begin
          stall = 1'b1;
          op_d  = in_op;
          rd_d  = md_if.rd_addr_i;
          if (in_is_mul) begin
            a_d     = in_a;
            b_d     = in_b;
            state_d = S_MUL;
          end else if (div_by_zero || div_ovf) begin
            res_d    = special_res;
            rd_out_d = md_if.rd_addr_i;
            state_d  = S_DONE;
          end else begin
            a_d     = a_mag;
            b_d     = b_mag;
            rem_d   = '0;
            cnt_d   = 5'd31;
            negq_d  = in_signed & (in_a[31] ^ in_b[31]);
            negr_d  = in_signed & in_a[31];
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        stall    = 1'b1;
        res_d    = (op_q == milano_pkg::MD_MUL) ? prod[31:0] : prod[63:32];
        rd_out_d = rd_q;
        state_d  = S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        a_d   = q_next;
        rem_d = rem_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == '0) begin
          res_d    = op_is_rem ? r_final : q_final;
          rd_out_d = rd_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        valid   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= milano_pkg::MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign md_if.stall_req_o    = stall;
  assign md_if.result_valid_o = valid;
  assign md_if.result_o       = res_q;
  assign md_if.rd_addr_o      = rd_out_q;
  assign md_if.rd_wr_en_o     = valid && (rd_out_q != '0);

endmodule
